mc_control: RTL and testbench

- Multicycle control FSM. It is the producing end of the ALU interface: it drives `ALUcontrol`, selects the operand sources and consumes the ALU's `zero` flag.
- Sequences fetch, decode, execute, memory and writeback for the MIPS subset lw/sw/R-type/addi/beq/j.
- Sits beside the datapath; all datapath register enables come from here.

---
 rtl/mc_pkg.sv | 51 +++++
 rtl/alu_funct_map.sv | 26 ++
 rtl/mc_control.sv | 229 ++++++++++++++++++++++
 tb/tb_mc_control.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_pkg.sv
// mc_pkg: shared types and encodings for the multicycle control path.
//   state_e        : 4-bit FSM state encoding (also driven on the State debug port)
//   OP_* / FN_*    : MIPS opcode and R-type funct field values
//   ALU_*          : ALUcontrol encodings
//   SRCB_* / PCSRC_*: operand B and PC source select encodings
package mc_pkg;

   typedef enum logic [3:0] {
      FETCH   = 4'd0,
      DECODE  = 4'd1,
      MEMADDR = 4'd2,
      MEMRD   = 4'd3,
      MEMWB   = 4'd4,
      MEMWR   = 4'd5,
      EXEC_R  = 4'd6,
      ALUWB_R = 4'd7,
      EXEC_I  = 4'd8,
      ALUWB_I = 4'd9,
      BRANCH  = 4'd10,
      JUMP    = 4'd11
   } state_e;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;

   localparam logic [5:0] FN_ADD = 6'b100000;
   localparam logic [5:0] FN_SUB = 6'b100010;
   localparam logic [5:0] FN_AND = 6'b100100;
   localparam logic [5:0] FN_OR  = 6'b100101;
   localparam logic [5:0] FN_SLT = 6'b101010;

   localparam logic [3:0] ALU_AND = 4'b0000;
   localparam logic [3:0] ALU_OR  = 4'b0001;
   localparam logic [3:0] ALU_ADD = 4'b0010;
   localparam logic [3:0] ALU_SUB = 4'b0110;
   localparam logic [3:0] ALU_SLT = 4'b0111;

   localparam logic [1:0] SRCB_B       = 2'b00;
   localparam logic [1:0] SRCB_FOUR    = 2'b01;
   localparam logic [1:0] SRCB_IMM     = 2'b10;
   localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/alu_funct_map.sv
// alu_funct_map: combinational R-type Funct to ALUcontrol decode.
//   funct    in  6  instruction Funct field
//   alu_ctrl out 4  ALU operation (add when funct is unknown)
//   valid    out 1  funct is one of add/sub/and/or/slt
module alu_funct_map
   import mc_pkg::*;
(
   input  logic [5:0] funct,
   output logic [3:0] alu_ctrl,
   output logic       valid
);

   always_comb begin
      alu_ctrl = ALU_ADD;
      valid    = 1'b1;
      case (funct)
         FN_ADD:  alu_ctrl = ALU_ADD;
         FN_SUB:  alu_ctrl = ALU_SUB;
         FN_AND:  alu_ctrl = ALU_AND;
         FN_OR:   alu_ctrl = ALU_OR;
         FN_SLT:  alu_ctrl = ALU_SLT;
         default: valid    = 1'b0;
      endcase
   end

endmodule

// File: rtl/mc_control.sv
// mc_control: multicycle MIPS control FSM (lw/sw/R-type/addi/beq/j).
//   clk, rst_n           : clock, asynchronous active-low reset
//   Opcode, Funct        : instruction fields, sampled in DECODE
//   zero                 : ALU flag, low when the compared operands are equal
//   MemReady             : memory handshake, access completes when sampled high
//   PCEn .. ALUcontrol   : datapath enables, selects and ALU operation
//   Done, Illegal        : one-cycle completion / error pulses
//   State                : current state for debug
// Only the state, the memory wait counter and the latched op/funct are registered;
// every output is decoded from them combinationally.
module mc_control
   import mc_pkg::*;
#(
   parameter int unsigned MEM_WAIT_MAX = 15
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [5:0] Opcode,
   input  logic [5:0] Funct,
   input  logic       zero,
   input  logic       MemReady,
   output logic       PCEn,
   output logic       IorD,
   output logic       MemRead,
   output logic       MemWrite,
   output logic       IRWrite,
   output logic       MemtoReg,
   output logic       RegDst,
   output logic       RegWrite,
   output logic       ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [1:0] PCSource,
   output logic [3:0] ALUcontrol,
   output logic       Done,
   output logic       Illegal,
   output logic [3:0] State
);

   localparam int unsigned CntW = (MEM_WAIT_MAX > 0) ? $clog2(MEM_WAIT_MAX + 1) : 1;

   state_e            state_q, state_d;
   logic [CntW-1:0]   cnt_q, cnt_d;
   logic [5:0]        op_q, funct_q;
   logic [5:0]        funct_sel;
   logic [3:0]        r_ctrl;
   logic              r_valid;
   logic              mem_state;
   logic              timeout;

   // DECODE validates the live Funct; EXEC_R uses the copy latched at the end of DECODE.
   assign funct_sel = (state_q == DECODE) ? Funct : funct_q;

   alu_funct_map u_funct_map (
      .funct    (funct_sel),
      .alu_ctrl (r_ctrl),
      .valid    (r_valid)
   );

   assign mem_state = (state_q == FETCH) || (state_q == MEMRD) || (state_q == MEMWR);

   // MemReady takes priority over an expiring wait.
   assign timeout = (MEM_WAIT_MAX != 0) && mem_state && !MemReady &&
                    (cnt_q == CntW'(MEM_WAIT_MAX));

   // Counter runs while a memory state is stalled; any exit or abort clears it,
   // so it is zero on every entry to FETCH, MEMRD and MEMWR.
   assign cnt_d = (mem_state && !MemReady && !timeout) ? cnt_q + 1'b1 : '0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= FETCH;
         cnt_q   <= '0;
         op_q    <= '0;
         funct_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (state_q == DECODE) begin
            op_q    <= Opcode;
            funct_q <= Funct;
         end
      end
   end

   always_comb begin
      state_d    = state_q;
      PCEn       = 1'b0;
      IorD       = 1'b0;
      MemRead    = 1'b0;
      MemWrite   = 1'b0;
      IRWrite    = 1'b0;
      MemtoReg   = 1'b0;
      RegDst     = 1'b0;
      RegWrite   = 1'b0;
      ALUSrcA    = 1'b0;
      ALUSrcB    = SRCB_B;
      PCSource   = PCSRC_ALU;
      ALUcontrol = ALU_ADD;
      Done       = 1'b0;
      Illegal    = 1'b0;

      case (state_q)
         FETCH: begin
            MemRead = 1'b1;
            ALUSrcB = SRCB_FOUR;
            if (MemReady) begin
               IRWrite = 1'b1;
               PCEn    = 1'b1;
               state_d = DECODE;
            end else if (timeout) begin
               Illegal = 1'b1;
               state_d = FETCH;
            end
         end
         DECODE: begin
            // ALUOut captures PC + (imm << 2) as the branch target.
            ALUSrcB = SRCB_IMM_SH2;
            case (Opcode)
               OP_LW, OP_SW: state_d = MEMADDR;
               OP_RTYPE: begin
                  if (r_valid) begin
                     state_d = EXEC_R;
                  end else begin
                     Illegal = 1'b1;
                     state_d = FETCH;
                  end
               end
               OP_ADDI: state_d = EXEC_I;
               OP_BEQ:  state_d = BRANCH;
               OP_J:    state_d = JUMP;
               default: begin
                  Illegal = 1'b1;
                  state_d = FETCH;
               end
            endcase
         end
         MEMADDR: begin
            ALUSrcA = 1'b1;
            ALUSrcB = SRCB_IMM;
            state_d = (op_q == OP_LW) ? MEMRD : MEMWR;
         end
         MEMRD: begin
            MemRead = 1'b1;
            IorD    = 1'b1;
            if (MemReady) begin
               state_d = MEMWB;
            end else if (timeout) begin
               Illegal = 1'b1;
               state_d = FETCH;
            end
         end
         MEMWB: begin
            RegWrite = 1'b1;
            MemtoReg = 1'b1;
            Done     = 1'b1;
            state_d  = FETCH;
         end
         MEMWR: begin
            MemWrite = 1'b1;
            IorD     = 1'b1;
            if (MemReady) begin
               Done    = 1'b1;
               state_d = FETCH;
            end else if (timeout) begin
               Illegal = 1'b1;
               state_d = FETCH;
            end
         end
         EXEC_R: begin
            ALUSrcA    = 1'b1;
            ALUcontrol = r_ctrl;
            state_d    = ALUWB_R;
         end
         ALUWB_R: begin
            RegWrite = 1'b1;
            RegDst   = 1'b1;
            Done     = 1'b1;
            state_d  = FETCH;
         end
         EXEC_I: begin
            ALUSrcA = 1'b1;
            ALUSrcB = SRCB_IMM;
            state_d = ALUWB_I;
         end
         ALUWB_I: begin
            RegWrite = 1'b1;
            Done     = 1'b1;
            state_d  = FETCH;
         end
         BRANCH: begin
            // ALU reports zero low on equality, so the branch is taken on ~zero.
            ALUSrcA    = 1'b1;
            ALUcontrol = ALU_SUB;
            PCSource   = PCSRC_ALUOUT;
            PCEn       = ~zero;
            Done       = 1'b1;
            state_d    = FETCH;
         end
         JUMP: begin
            PCSource = PCSRC_JUMP;
            PCEn     = 1'b1;
            Done     = 1'b1;
            state_d  = FETCH;
         end
         default: state_d = FETCH;
      endcase

      // While reset is held the FSM sits in FETCH, but requests must stay quiet.
      if (!rst_n) begin
         PCEn     = 1'b0;
         IorD     = 1'b0;
         MemRead  = 1'b0;
         MemWrite = 1'b0;
         IRWrite  = 1'b0;
         MemtoReg = 1'b0;
         RegDst   = 1'b0;
         RegWrite = 1'b0;
         ALUSrcA  = 1'b0;
         ALUSrcB  = SRCB_B;
         PCSource = PCSRC_ALU;
         ALUcontrol = ALU_ADD;
         Done     = 1'b0;
         Illegal  = 1'b0;
      end
   end

   assign State = state_q;

endmodule

// File: tb/tb_mc_control.sv
module tb_mc_control;
   import mc_pkg::*;

   localparam int unsigned WaitMax = 15;

   logic       clk, rst_n;
   logic [5:0] Opcode, Funct;
   logic       zero, MemReady;
   logic       PCEn, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst, RegWrite, ALUSrcA;
   logic [1:0] ALUSrcB, PCSource;
   logic [3:0] ALUcontrol, State;
   logic       Done, Illegal;

   mc_control #(.MEM_WAIT_MAX(WaitMax)) dut (
      .clk(clk), .rst_n(rst_n), .Opcode(Opcode), .Funct(Funct), .zero(zero),
      .MemReady(MemReady), .PCEn(PCEn), .IorD(IorD), .MemRead(MemRead),
      .MemWrite(MemWrite), .IRWrite(IRWrite), .MemtoReg(MemtoReg), .RegDst(RegDst),
      .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .PCSource(PCSource),
      .ALUcontrol(ALUcontrol), .Done(Done), .Illegal(Illegal), .State(State)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic       pcen, iord, memread, memwrite, irwrite, memtoreg, regdst, regwrite, alusrca;
      logic [1:0] alusrcb, pcsource;
      logic [3:0] aluctl;
      logic       done, illegal;
      logic [3:0] st;
   } out_t;

   typedef struct {
      logic       rdy;
      logic       z;
      logic [5:0] op;
      logic [5:0] fn;
      out_t       exp;
   } cyc_t;

   out_t obs;
   assign obs = {PCEn, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst, RegWrite, ALUSrcA,
                 ALUSrcB, PCSource, ALUcontrol, Done, Illegal, State};

   cyc_t q[$];
   logic [3:0] fn_tab [logic [5:0]];
   int n_cmp = 0;
   int n_err = 0;

   function automatic logic [5:0] rnd6();
      return 6'($urandom);
   endfunction

   function automatic logic rbit();
      return 1'($urandom);
   endfunction

   // Quiet outputs for a given state: nothing enabled, add on the ALU.
   function automatic out_t idle(input state_e s);
      out_t o;
      o = '0;
      o.aluctl = 4'b0010;
      o.st = s;
      return o;
   endfunction

   task automatic push_cyc(input logic rdy, input logic z, input logic [5:0] op,
                           input logic [5:0] fn, input out_t e);
      cyc_t c;
      c.rdy = rdy; c.z = z; c.op = op; c.fn = fn; c.exp = e;
      q.push_back(c);
   endtask

   // Stalled memory cycles; the cycle where the wait count reaches WaitMax aborts.
   task automatic build_wait(input out_t tmpl, input int waits, output bit aborted);
      out_t e;
      aborted = 1'b0;
      for (int i = 0; i < waits; i++) begin
         e = tmpl;
         if (i == int'(WaitMax)) begin
            e.illegal = 1'b1;
            push_cyc(1'b0, rbit(), rnd6(), rnd6(), e);
            aborted = 1'b1;
            return;
         end
         push_cyc(1'b0, rbit(), rnd6(), rnd6(), e);
      end
   endtask

   // Reference sequence for one instruction. bz < 0 means random zero at the branch.
   task automatic build_instr(input logic [5:0] op, input logic [5:0] fn, input int fw,
                              input int mw, input int bz);
      out_t e;
      bit   ab, legal;
      logic zb;
      q.delete();
      e = idle(FETCH); e.memread = 1'b1; e.alusrcb = 2'b01;
      build_wait(e, fw, ab);
      if (ab) return;
      e.irwrite = 1'b1; e.pcen = 1'b1;
      push_cyc(1'b1, rbit(), rnd6(), rnd6(), e);

      case (op)
         6'b100011, 6'b101011, 6'b001000, 6'b000100, 6'b000010: legal = 1'b1;
         6'b000000: legal = fn_tab.exists(fn);
         default:   legal = 1'b0;
      endcase
      e = idle(DECODE); e.alusrcb = 2'b11; e.illegal = ~legal;
      push_cyc(rbit(), rbit(), op, fn, e);
      if (!legal) return;

      case (op)
         6'b100011, 6'b101011: begin
            e = idle(MEMADDR); e.alusrca = 1'b1; e.alusrcb = 2'b10;
            push_cyc(rbit(), rbit(), rnd6(), rnd6(), e);
            if (op == 6'b100011) begin
               e = idle(MEMRD); e.memread = 1'b1;
            end else begin
               e = idle(MEMWR); e.memwrite = 1'b1;
            end
            e.iord = 1'b1;
            build_wait(e, mw, ab);
            if (ab) return;
            if (op == 6'b101011) e.done = 1'b1;
            push_cyc(1'b1, rbit(), rnd6(), rnd6(), e);
            if (op == 6'b100011) begin
               e = idle(MEMWB); e.regwrite = 1'b1; e.memtoreg = 1'b1; e.done = 1'b1;
               push_cyc(rbit(), rbit(), rnd6(), rnd6(), e);
            end
         end
         6'b000000: begin
            e = idle(EXEC_R); e.alusrca = 1'b1; e.aluctl = fn_tab[fn];
            push_cyc(rbit(), rbit(), rnd6(), rnd6(), e);
            e = idle(ALUWB_R); e.regwrite = 1'b1; e.regdst = 1'b1; e.done = 1'b1;
            push_cyc(rbit(), rbit(), rnd6(), rnd6(), e);
         end
         6'b001000: begin
            e = idle(EXEC_I); e.alusrca = 1'b1; e.alusrcb = 2'b10;
            push_cyc(rbit(), rbit(), rnd6(), rnd6(), e);
            e = idle(ALUWB_I); e.regwrite = 1'b1; e.done = 1'b1;
            push_cyc(rbit(), rbit(), rnd6(), rnd6(), e);
         end
         6'b000100: begin
            zb = (bz < 0) ? rbit() : 1'(bz);
            e = idle(BRANCH); e.alusrca = 1'b1; e.aluctl = 4'b0110; e.pcsource = 2'b01;
            e.pcen = ~zb; e.done = 1'b1;
            push_cyc(rbit(), zb, rnd6(), rnd6(), e);
         end
         default: begin
            e = idle(JUMP); e.pcsource = 2'b10; e.pcen = 1'b1; e.done = 1'b1;
            push_cyc(rbit(), rbit(), rnd6(), rnd6(), e);
         end
      endcase
   endtask

   task automatic run_queue(input string name);
      for (int i = 0; i < q.size(); i++) begin
         @(negedge clk);
         MemReady = q[i].rdy; zero = q[i].z; Opcode = q[i].op; Funct = q[i].fn;
         #1;
         n_cmp++;
         if (obs !== q[i].exp) begin
            n_err++;
            $display("FAIL %s cycle %0d: outputs got %h want %h", name, i, obs, q[i].exp);
         end
      end
   endtask

   task automatic test_reset();
      out_t rv;
      rv = idle(FETCH);
      rst_n = 1'b0; MemReady = 1'b1; zero = 1'b0; Opcode = 6'b100011; Funct = 6'b0;
      #2;
      n_cmp++;
      if (obs !== rv) begin
         n_err++; $display("FAIL reset_hold: got %h want %h", obs, rv);
      end
      @(negedge clk); @(negedge clk);
      MemReady = 1'b0;
      rst_n = 1'b1;
      @(posedge clk); #1;
      n_cmp++;
      if (State !== 4'd0 || MemRead !== 1'b1 || IRWrite !== 1'b0) begin
         n_err++;
         $display("FAIL reset_release: State %0d MemRead %b IRWrite %b want 0 1 0",
                  State, MemRead, IRWrite);
      end
   endtask

   task automatic test_reset_mid();
      out_t rv;
      rv = idle(FETCH);
      @(negedge clk); MemReady = 1'b1; Opcode = 6'b100011; Funct = rnd6();
      @(negedge clk);
      @(negedge clk); MemReady = 1'b0;
      @(negedge clk); #1;
      n_cmp++;
      if (State !== 4'd3 || MemRead !== 1'b1 || IorD !== 1'b1) begin
         n_err++;
         $display("FAIL reset_mid_pre: State %0d MemRead %b IorD %b want 3 1 1",
                  State, MemRead, IorD);
      end
      rst_n = 1'b0; #1;
      n_cmp++;
      if (obs !== rv) begin
         n_err++; $display("FAIL reset_mid_assert: got %h want %h", obs, rv);
      end
      @(negedge clk); @(negedge clk); #1;
      n_cmp++;
      if (obs !== rv) begin
         n_err++; $display("FAIL reset_mid_held: got %h want %h", obs, rv);
      end
      rst_n = 1'b1;
      @(posedge clk); #1;
      n_cmp++;
      if (State !== 4'd0 || MemRead !== 1'b1) begin
         n_err++;
         $display("FAIL reset_mid_release: State %0d MemRead %b want 0 1", State, MemRead);
      end
   endtask

   task automatic test_rtype_sub();
      build_instr(6'b000000, 6'b100010, 0, 0, -1);
      run_queue("rtype_sub");
   endtask

   task automatic test_lw_waits();
      build_instr(6'b100011, rnd6(), 3, 2, -1);
      run_queue("lw_waits");
   endtask

   task automatic test_beq();
      build_instr(6'b000100, rnd6(), 0, 0, 0);
      run_queue("beq_taken");
      build_instr(6'b000100, rnd6(), 0, 0, 1);
      run_queue("beq_not_taken");
   endtask

   task automatic test_illegal();
      build_instr(6'b111111, rnd6(), 0, 0, -1);
      run_queue("illegal_opcode");
      build_instr(6'b000000, 6'b000111, 1, 0, -1);
      run_queue("illegal_funct");
   endtask

   task automatic test_timeout();
      build_instr(6'b101011, rnd6(), 0, 20, -1);
      run_queue("sw_timeout");
      build_instr(6'b100011, rnd6(), 0, 16, -1);
      run_queue("lw_timeout");
      build_instr(6'b000010, rnd6(), 18, 0, -1);
      run_queue("fetch_timeout");
      build_instr(6'b101011, rnd6(), 14, 14, -1);
      run_queue("sw_just_ready");
   endtask

   task automatic test_latency();
      logic [5:0] ops [6] = '{6'b100011, 6'b101011, 6'b000000, 6'b001000, 6'b000100, 6'b000010};
      int         lat [6] = '{5, 4, 4, 4, 3, 3};
      int  cyc;
      bit  got;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         MemReady = 1'b1; Opcode = ops[k]; Funct = 6'b100000; zero = rbit();
         cyc = 0; got = 1'b0;
         for (int c = 0; c < 20 && !got; c++) begin
            if (c > 0) @(negedge clk);
            #1;
            cyc++;
            if (Done === 1'b1) got = 1'b1;
         end
         n_cmp++;
         if (!got || cyc != lat[k]) begin
            n_err++;
            $display("FAIL latency op %b: got %0d cycles (done seen %0d) want %0d",
                     ops[k], cyc, got, lat[k]);
            rst_n = 1'b0; #1; rst_n = 1'b1;
         end
      end
   endtask

   task automatic test_random();
      logic [5:0] ops [7];
      logic [5:0] fns [5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
      logic [5:0] op, fn;
      int fw, mw;
      for (int n = 0; n < 80; n++) begin
         ops = '{6'b100011, 6'b101011, 6'b000000, 6'b001000, 6'b000100, 6'b000010, rnd6()};
         op = ops[$urandom_range(0, 6)];
         fn = ($urandom_range(0, 9) < 8) ? fns[$urandom_range(0, 4)] : rnd6();
         fw = ($urandom_range(0, 9) == 0) ? $urandom_range(13, 17) : $urandom_range(0, 3);
         mw = ($urandom_range(0, 9) == 0) ? $urandom_range(13, 17) : $urandom_range(0, 3);
         build_instr(op, fn, fw, mw, -1);
         run_queue("random");
      end
      @(negedge clk); #1;
      n_cmp++;
      if (State !== 4'd0) begin
         n_err++; $display("FAIL random_end_state: got %0d want 0", State);
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, got timeout want completion");
      $fatal(1);
   end

   initial begin
      fn_tab[6'b100000] = 4'b0010;
      fn_tab[6'b100010] = 4'b0110;
      fn_tab[6'b100100] = 4'b0000;
      fn_tab[6'b100101] = 4'b0001;
      fn_tab[6'b101010] = 4'b0111;
      test_reset();
      test_reset_mid();
      test_rtype_sub();
      test_lw_waits();
      test_beq();
      test_illegal();
      test_timeout();
      test_latency();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
